// File: rtl/riscv_pkg.sv
// riscv_pkg: shared core constants and the fetch entry type used by Fetch and Decode
package riscv_pkg;
  localparam int XLEN = 32;
  localparam logic [31:0] NOP_INST = 32'h00000013;
  typedef struct packed {
    logic [XLEN-1:0] pc;
    logic [XLEN-1:0] inst;
  } fetch_entry_t;
endpackage

// File: rtl/fetch_queue_mem.sv
// fetch_queue_mem: entry storage with synchronous write and asynchronous read, no reset
module fetch_queue_mem #(
  parameter int DEPTH = 4,
  parameter int W = 64,
  localparam int AW = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          we,
  input  logic [AW-1:0] waddr,
  input  logic [W-1:0]  wdata,
  input  logic [AW-1:0] raddr,
  output logic [W-1:0]  rdata
);
  logic [W-1:0] mem [DEPTH];
  always_ff @(posedge clk)
    if (we) mem[waddr] <= wdata;
  assign rdata = mem[raddr];
endmodule

// File: rtl/fetch_queue.sv
// fetch_queue: show-ahead instruction buffer between Fetch and Decode with one-cycle flush
module fetch_queue #(
  parameter int DEPTH = 4,
  parameter int XLEN = riscv_pkg::XLEN,
  localparam int PTR_W = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             flush,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [XLEN-1:0]  in_pc,
  input  logic [XLEN-1:0]  in_inst,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [XLEN-1:0]  out_pc,
  output logic [XLEN-1:0]  out_inst,
  output logic [PTR_W:0]   count
);
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [PTR_W:0] count_q, count_d;
  logic [2*XLEN-1:0] rdata;
  logic push, pop;
  // in_ready looks only at occupancy, never at out_ready
  assign in_ready = rst & (count_q != (PTR_W+1)'(DEPTH));
  assign out_valid = count_q != '0;
  assign push = in_valid & in_ready & ~flush;
  assign pop = out_valid & out_ready & ~flush;
  assign count = count_q;
  assign out_pc = out_valid ? rdata[2*XLEN-1:XLEN] : '0;
  assign out_inst = out_valid ? rdata[XLEN-1:0] : XLEN'(riscv_pkg::NOP_INST);
  always_comb begin
    wr_ptr_d = flush ? '0 : wr_ptr_q + PTR_W'(push);
    rd_ptr_d = flush ? '0 : rd_ptr_q + PTR_W'(pop);
    count_d = flush ? '0 : count_q + (PTR_W+1)'(push) - (PTR_W+1)'(pop);
  end
  always_ff @(posedge clk or negedge rst)
    if (!rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q <= count_d;
    end
  fetch_queue_mem #(.DEPTH(DEPTH), .W(2*XLEN)) u_mem (
    .clk(clk),
    .we(push),
    .waddr(wr_ptr_q),
    .wdata({in_pc, in_inst}),
    .raddr(rd_ptr_q),
    .rdata(rdata)
  );
endmodule
